sirv_qspi_xip_seq: RTL
======================

Name: sirv_qspi_xip_seq

Overview:
- Hardware read sequencer for memory-mapped (XIP) access to serial flash.
- Converts a single 32-bit read request into the frame sequence command, address, optional dummy, then data.
- Drives one inner port of the QSPI arbiter using that port's frame-link semantics.
- Holds the arbiter lock and chip-select for the whole transaction.

Parameters:
- DATA_BYTES, 4: data frames per read (fixed 4; resp_data width = 8*DATA_BYTES).

Ports:
- clock  in  1  clock
- reset  in  1  synchronous reset, active-high
- req_valid  in  1  read request valid
- req_ready  out  1  request accepted when req_valid&req_ready
- req_addr  in  32  byte address; bits [23:0] used, or [31:0] when cfg_addr_4b=1
- resp_valid  out  1  read data valid
- resp_ready  in  1  response consumed
- resp_data  out  32  read data, first received byte in [7:0]
- cfg_cmd_code  in  8  flash command opcode
- cfg_cmd_proto  in  2  proto for command frame
- cfg_addr_proto  in  2  proto for address/dummy frames
- cfg_data_proto  in  2  proto for data frames
- cfg_addr_4b  in  1  0: 3 address bytes, 1: 4 address bytes
- cfg_pad_cnt  in  4  dummy bit-cycles; 0 means no dummy frame
- tx_ready  in  1  link accepts frame
- tx_valid  out  1  frame valid
- tx_bits  out  8  frame payload
- rx_valid  in  1  one received byte per RX frame
- rx_bits  in  8  received byte
- cnt  out  8  bit-cycles of current frame
- fmt_proto  out  2  proto of current frame
- fmt_endian  out  1  constant 0 (MSB first)
- fmt_iodir  out  1  1 = TX frame, 0 = RX frame
- cs_set  out  1  constant 1
- cs_clear  out  1  constant 0
- cs_hold  out  1  keep CS asserted between frames
- lock  out  1  hold arbiter selection
- active  in  1  link busy (status only; not used for sequencing)

Behaviour:
- Link semantics:
  - One frame transfers per tx_valid&tx_ready.
  - Frames with fmt_iodir=0 return exactly one rx_valid later, in order.
  - Frames with fmt_iodir=1 return none.
- Reset (synchronous): state=IDLE; counters 0; resp_data=0.
  - Outputs: req_ready=1; tx_valid=0; resp_valid=0; lock=0; cs_hold=0; tx_bits=0; cnt=8; fmt_proto=0; fmt_iodir=1.
  - Reset mid-transaction aborts immediately; in-flight rx_valid after reset is ignored.
- Request accept: on req_valid&req_ready in IDLE, register address and all cfg_* (cfg changes afterward have no effect); next state CMD.
- CMD: tx_valid=1, tx_bits=cmd, cnt=8, proto=cmd_proto, iodir=1. On handshake go to ADDR with byte index = 3 (4b) or 2 (3b).
- ADDR: tx_bits=addr byte at index (MSB first), cnt=8, proto=addr_proto, iodir=1. On handshake at index 0:
  - go to PAD if pad_cnt!=0, else DATA.
  - otherwise decrement the index.
- PAD: tx_bits=0, cnt={4'b0,pad_cnt}, proto=addr_proto, iodir=0. On handshake go to DATA. The returned rx byte is discarded (skip counter set to 1).
- DATA: tx_bits=0, cnt=8, proto=data_proto, iodir=0. After DATA_BYTES handshakes go to WAIT.
- rx capture (any state except IDLE/RESP):
  - If the skip counter is nonzero, decrement it and drop the byte.
  - Otherwise write rx_bits to byte lane rxidx and increment rxidx.
  - Pad rx and data tx handshake in the same cycle are handled independently.
- WAIT: tx_valid=0. When rxidx reaches DATA_BYTES (including the cycle of the last rx_valid), go to RESP.
- RESP: resp_valid=1, lock=0, cs_hold=0; hold until resp_ready, then return to IDLE. resp_data is stable while resp_valid=1.
- Status outputs:
  - lock=1 and cs_hold=1 in CMD, ADDR, PAD, DATA, WAIT; 0 otherwise.
  - req_ready=1 only in IDLE.
- tx_valid, once asserted, stays asserted with stable payload/fmt until tx_ready.
- rx_valid in IDLE/RESP is ignored.

Test Plan:
- Basic 3B read:
  - Stimulus: cmd=0x03, addr 0x00123456, pad=0, tx_ready=1.
  - Response: TX frames 03,12,34,56, then 4 RX frames; rx AA,BB,CC,DD gives resp_data=0xDDCCBBAA.
  - lock=1 from cycle after accept until RESP.
- 4B quad fast read:
  - Stimulus: cmd=0xEC, cmd_proto=0, addr_proto=2, data_proto=2, addr 0x89ABCDEF, pad=6.
  - Response: frames EC,89,AB,CD,EF, then a pad frame cnt=6 iodir=0; first rx byte discarded; data protos=2.
- Backpressure:
  - Stimulus: tx_ready toggles 0/1 every cycle; rx_valid delayed 5 cycles.
  - Response: tx_bits/cnt/fmt stable while tx_valid&!tx_ready; identical frame order; WAIT held until the 4th rx.
- Response stall:
  - Stimulus: resp_ready=0 for 10 cycles, new req_valid asserted.
  - Response: resp_valid and resp_data stable; req_ready=0 until the cycle after resp_ready.
- Reset mid-op:
  - Stimulus: assert reset during ADDR, then deliver a stray rx_valid.
  - Response: next cycle IDLE, lock=0, tx_valid=0, req_ready=1; stray rx does not alter resp_data.
- Config change after accept:
  - Stimulus: change cfg_cmd_code 0x03 to 0x0B in the cycle after accept.
  - Response: transmitted command is still 0x03.

Source files
------------

// File: rtl/sirv_qspi_xip_seq.sv
// sirv_qspi_xip_seq: XIP read sequencer issuing cmd/addr/pad/data frames on one QSPI arbiter port
module sirv_qspi_xip_seq #(
   parameter int DATA_BYTES = 4
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    req_valid,
   output logic                    req_ready,
   input  logic [31:0]             req_addr,
   output logic                    resp_valid,
   input  logic                    resp_ready,
   output logic [8*DATA_BYTES-1:0] resp_data,
   input  logic [7:0]              cfg_cmd_code,
   input  logic [1:0]              cfg_cmd_proto,
   input  logic [1:0]              cfg_addr_proto,
   input  logic [1:0]              cfg_data_proto,
   input  logic                    cfg_addr_4b,
   input  logic [3:0]              cfg_pad_cnt,
   input  logic                    tx_ready,
   output logic                    tx_valid,
   output logic [7:0]              tx_bits,
   input  logic                    rx_valid,
   input  logic [7:0]              rx_bits,
   output logic [7:0]              cnt,
   output logic [1:0]              fmt_proto,
   output logic                    fmt_endian,
   output logic                    fmt_iodir,
   output logic                    cs_set,
   output logic                    cs_clear,
   output logic                    cs_hold,
   output logic                    lock,
   input  logic                    active
);
   typedef enum logic [2:0] {S_IDLE, S_CMD, S_ADDR, S_PAD, S_DATA, S_WAIT, S_RESP} state_t;
   localparam logic [2:0] NB = 3'(DATA_BYTES);
   localparam logic [2:0] LAST = 3'(DATA_BYTES - 1);
   state_t      r_state;
   logic [31:0] r_addr;
   logic [1:0]  r_addr_proto, r_data_proto, r_idx;
   logic        r_addr_4b, r_skip;
   logic [3:0]  r_pad;
   logic [2:0]  r_dcnt, r_rxidx;
   logic        w_hs, w_rx, w_cap, w_rx_done, w_unused;
   logic [1:0]  w_idx0, w_idx_m1;
   assign fmt_endian = 1'b0;
   assign cs_set     = 1'b1;
   assign cs_clear   = 1'b0;
   assign w_unused   = active;
   assign w_hs       = tx_valid & tx_ready;
   assign w_rx       = rx_valid && r_state != S_IDLE && r_state != S_RESP;
   assign w_cap      = w_rx && !r_skip;
   assign w_rx_done  = r_rxidx == NB || (w_cap && r_rxidx == LAST);
   assign w_idx0     = r_addr_4b ? 2'd3 : 2'd2;
   assign w_idx_m1   = r_idx - 2'd1;
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state    <= S_IDLE;
         r_idx      <= '0;
         r_dcnt     <= '0;
         r_rxidx    <= '0;
         r_skip     <= 1'b0;
         resp_data  <= '0;
         req_ready  <= 1'b1;
         tx_valid   <= 1'b0;
         resp_valid <= 1'b0;
         lock       <= 1'b0;
         cs_hold    <= 1'b0;
         tx_bits    <= '0;
         cnt        <= 8'd8;
         fmt_proto  <= '0;
         fmt_iodir  <= 1'b1;
      end else begin
         // the pad frame's returned byte is dropped; everything else fills lanes in order
         if (w_rx) begin
            if (r_skip) r_skip <= 1'b0;
            else begin
               resp_data[{r_rxidx[1:0], 3'b000} +: 8] <= rx_bits;
               r_rxidx <= r_rxidx + 3'd1;
            end
         end
         case (r_state)
            S_IDLE: if (req_valid) begin
               r_state      <= S_CMD;
               r_addr       <= req_addr;
               r_addr_proto <= cfg_addr_proto;
               r_data_proto <= cfg_data_proto;
               r_addr_4b    <= cfg_addr_4b;
               r_pad        <= cfg_pad_cnt;
               r_dcnt       <= '0;
               r_rxidx      <= '0;
               r_skip       <= 1'b0;
               req_ready    <= 1'b0;
               tx_valid     <= 1'b1;
               tx_bits      <= cfg_cmd_code;
               cnt          <= 8'd8;
               fmt_proto    <= cfg_cmd_proto;
               fmt_iodir    <= 1'b1;
               lock         <= 1'b1;
               cs_hold      <= 1'b1;
            end
            S_CMD: if (w_hs) begin
               r_state   <= S_ADDR;
               r_idx     <= w_idx0;
               tx_bits   <= r_addr[{w_idx0, 3'b000} +: 8];
               fmt_proto <= r_addr_proto;
            end
            S_ADDR: if (w_hs) begin
               if (r_idx != 2'd0) begin
                  r_idx   <= w_idx_m1;
                  tx_bits <= r_addr[{w_idx_m1, 3'b000} +: 8];
               end else if (r_pad != 4'd0) begin
                  r_state   <= S_PAD;
                  tx_bits   <= '0;
                  cnt       <= {4'b0000, r_pad};
                  fmt_iodir <= 1'b0;
               end else begin
                  r_state   <= S_DATA;
                  tx_bits   <= '0;
                  fmt_proto <= r_data_proto;
                  fmt_iodir <= 1'b0;
               end
            end
            S_PAD: if (w_hs) begin
               r_state   <= S_DATA;
               r_skip    <= 1'b1;
               cnt       <= 8'd8;
               fmt_proto <= r_data_proto;
            end
            S_DATA: if (w_hs) begin
               r_dcnt <= r_dcnt + 3'd1;
               if (r_dcnt == LAST) begin
                  r_state  <= S_WAIT;
                  tx_valid <= 1'b0;
               end
            end
            S_WAIT: if (w_rx_done) begin
               r_state    <= S_RESP;
               resp_valid <= 1'b1;
               lock       <= 1'b0;
               cs_hold    <= 1'b0;
               cnt        <= 8'd8;
               fmt_proto  <= '0;
               fmt_iodir  <= 1'b1;
            end
            S_RESP: if (resp_ready) begin
               r_state    <= S_IDLE;
               resp_valid <= 1'b0;
               req_ready  <= 1'b1;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end
endmodule
